// File: rtl/pcap_record_framer.sv
// Purpose: timestamps each packet at SOP, truncates it to SNAPLEN and queues one
//          pcap record header {caplen, len, ts_sec, ts_usec} per packet.
// Latency: data path is combinational; a header becomes visible one cycle after its EOP word is accepted.
// Backpressure: forwarded words follow TX_READY; dropped words are always taken; EOP words also wait for a header slot.
// Ports: CLK/RESET_N; TS_* free-running timestamp; RX_* packet input (valid/ready);
//        TX_* truncated packet output (valid/ready); HDR_* header FIFO output; ORPHAN_ERR pulse.
module pcap_record_framer #(
  parameter int DATA_WIDTH     = 64,
  parameter int SNAPLEN        = 65535,
  parameter int HDR_FIFO_DEPTH = 8
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic [31:0]                       TS_SEC,
  input  logic [31:0]                       TS_USEC,
  input  logic [DATA_WIDTH-1:0]             RX_DATA,
  input  logic                              RX_SOP,
  input  logic                              RX_EOP,
  input  logic [$clog2(DATA_WIDTH/8):0]     RX_EOP_BYTES,
  input  logic                              RX_VALID,
  output logic                              RX_READY,
  output logic [DATA_WIDTH-1:0]             TX_DATA,
  output logic                              TX_SOP,
  output logic                              TX_EOP,
  output logic [$clog2(DATA_WIDTH/8):0]     TX_EOP_BYTES,
  output logic                              TX_VALID,
  input  logic                              TX_READY,
  output logic [31:0]                       HDR_CAPLEN,
  output logic [31:0]                       HDR_LEN,
  output logic [31:0]                       HDR_TS_SEC,
  output logic [31:0]                       HDR_TS_USEC,
  output logic                              HDR_VALID,
  input  logic                              HDR_READY,
  output logic                              ORPHAN_ERR
);

  localparam int              BYTES     = DATA_WIDTH / 8;
  localparam int              BW        = $clog2(BYTES) + 1;
  localparam int              AW        = $clog2(HDR_FIFO_DEPTH);
  localparam logic [32:0]     SNAP33    = 33'(SNAPLEN);
  localparam logic [BW-1:0]   FULL_WORD = BW'(BYTES);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  typedef struct packed {
    logic [31:0] caplen;
    logic [31:0] len;
    logic [31:0] ts_sec;
    logic [31:0] ts_usec;
  } hdr_t;

  state_t      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] ts_sec_q, ts_sec_d;
  logic [31:0] ts_usec_q, ts_usec_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  hdr_t        mem_q [HDR_FIFO_DEPTH];

  logic [BW-1:0] word_bytes;
  logic [31:0]   bytes_before;
  logic [32:0]   cum;
  logic [31:0]   len_new;
  logic [31:0]   caplen_new;
  logic          fwd_word;
  logic          hit;
  logic          fifo_full;
  logic          fifo_empty;
  logic          hdr_block;
  logic          rx_ready_w;
  logic          accept;
  logic          push;
  logic          pop;
  logic          tx_valid_w;
  logic          tx_eop_w;
  logic [BW-1:0] tx_eop_bytes_w;
  hdr_t          push_dat;
  hdr_t          hdr_out;

  // Datapath, handshake and header-FIFO control
  always_comb begin
    word_bytes   = RX_EOP ? RX_EOP_BYTES : FULL_WORD;
    // A word is forwarded when it opens a packet in IDLE or continues one in PASS
    fwd_word     = ((state_q == IDLE) && RX_SOP) || (state_q == PASS);
    bytes_before = (state_q == IDLE) ? 32'd0 : len_q;
    cum          = {1'b0, bytes_before} + 33'(word_bytes);
    hit          = (cum >= SNAP33);
    len_new      = cum[32] ? 32'hFFFF_FFFF : cum[31:0];
    caplen_new   = ({1'b0, len_new} > SNAP33) ? SNAP33[31:0] : len_new;

    tx_eop_w       = hit || RX_EOP;
    // On the truncating word only the bytes up to SNAPLEN are kept
    tx_eop_bytes_w = hit ? BW'(SNAP33 - {1'b0, bytes_before}) : word_bytes;

    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !fifo_empty && HDR_READY;
    // A same-cycle pop frees the slot, so only a full FIFO that is not draining blocks
    hdr_block  = RX_EOP && fifo_full && !HDR_READY;

    // Ready is derived from state and sideband only, never from RX_VALID
    rx_ready_w = RESET_N && !hdr_block && (fwd_word ? TX_READY : 1'b1);
    accept     = RX_VALID && rx_ready_w;
    // Hide the word from downstream while it waits for a header slot so it is not taken twice
    tx_valid_w = RESET_N && RX_VALID && fwd_word && !hdr_block;
    // Orphan words never produce a header
    push       = accept && RX_EOP && ((state_q != IDLE) || RX_SOP);

    push_dat.caplen  = caplen_new;
    push_dat.len     = len_new;
    push_dat.ts_sec  = (state_q == IDLE) ? TS_SEC  : ts_sec_q;
    push_dat.ts_usec = (state_q == IDLE) ? TS_USEC : ts_usec_q;

    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  // Packet FSM: length accumulation and timestamp capture
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ts_sec_d  = ts_sec_q;
    ts_usec_d = ts_usec_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (RX_SOP) begin
            ts_sec_d  = TS_SEC;
            ts_usec_d = TS_USEC;
            len_d     = len_new;
            state_d   = RX_EOP ? IDLE : (hit ? DROP : PASS);
          end
        end
        PASS: begin
          len_d   = len_new;
          state_d = RX_EOP ? IDLE : (hit ? DROP : PASS);
        end
        DROP: begin
          len_d = len_new;
          if (RX_EOP) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      len_q     <= '0;
      ts_sec_q  <= '0;
      ts_usec_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ts_sec_q  <= ts_sec_d;
      ts_usec_q <= ts_usec_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Header storage; contents are qualified by the pointers so it needs no reset
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

  assign hdr_out = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign RX_READY     = rx_ready_w;
  assign TX_VALID     = tx_valid_w;
  assign TX_DATA      = tx_valid_w ? RX_DATA : '0;
  assign TX_SOP       = tx_valid_w && (state_q == IDLE);
  assign TX_EOP       = tx_valid_w && tx_eop_w;
  assign TX_EOP_BYTES = (tx_valid_w && tx_eop_w) ? tx_eop_bytes_w : '0;
  assign HDR_VALID    = !fifo_empty;
  assign HDR_CAPLEN   = hdr_out.caplen;
  assign HDR_LEN      = hdr_out.len;
  assign HDR_TS_SEC   = hdr_out.ts_sec;
  assign HDR_TS_USEC  = hdr_out.ts_usec;
  assign ORPHAN_ERR   = accept && (state_q == IDLE) && !RX_SOP;

endmodule

// File: tb/tb_pcap_record_framer.sv
module tb_pcap_record_framer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] ts_sec, ts_usec;
  logic [63:0] rx_data;
  logic        rx_sop, rx_eop, rx_valid;
  logic [3:0]  rx_eop_bytes;
  logic        tx_ready, hdr_ready;
  logic        sel;  // 0: drive DUT a (SNAPLEN 65535), 1: drive DUT b (SNAPLEN 20)

  logic        rx_ready_a, tx_sop_a, tx_eop_a, tx_valid_a, hdr_valid_a, orphan_a;
  logic [63:0] tx_data_a;
  logic [3:0]  tx_eop_bytes_a;
  logic [31:0] hdr_caplen_a, hdr_len_a, hdr_sec_a, hdr_usec_a;
  logic        rx_ready_b, tx_sop_b, tx_eop_b, tx_valid_b, hdr_valid_b, orphan_b;
  logic [63:0] tx_data_b;
  logic [3:0]  tx_eop_bytes_b;
  logic [31:0] hdr_caplen_b, hdr_len_b, hdr_sec_b, hdr_usec_b;

  pcap_record_framer #(.DATA_WIDTH(64), .SNAPLEN(65535), .HDR_FIFO_DEPTH(8)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .TS_SEC(ts_sec), .TS_USEC(ts_usec),
    .RX_DATA(rx_data), .RX_SOP(rx_sop), .RX_EOP(rx_eop), .RX_EOP_BYTES(rx_eop_bytes),
    .RX_VALID(rx_valid && !sel), .RX_READY(rx_ready_a),
    .TX_DATA(tx_data_a), .TX_SOP(tx_sop_a), .TX_EOP(tx_eop_a), .TX_EOP_BYTES(tx_eop_bytes_a),
    .TX_VALID(tx_valid_a), .TX_READY(tx_ready),
    .HDR_CAPLEN(hdr_caplen_a), .HDR_LEN(hdr_len_a), .HDR_TS_SEC(hdr_sec_a), .HDR_TS_USEC(hdr_usec_a),
    .HDR_VALID(hdr_valid_a), .HDR_READY(hdr_ready), .ORPHAN_ERR(orphan_a));

  pcap_record_framer #(.DATA_WIDTH(64), .SNAPLEN(20), .HDR_FIFO_DEPTH(8)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .TS_SEC(ts_sec), .TS_USEC(ts_usec),
    .RX_DATA(rx_data), .RX_SOP(rx_sop), .RX_EOP(rx_eop), .RX_EOP_BYTES(rx_eop_bytes),
    .RX_VALID(rx_valid && sel), .RX_READY(rx_ready_b),
    .TX_DATA(tx_data_b), .TX_SOP(tx_sop_b), .TX_EOP(tx_eop_b), .TX_EOP_BYTES(tx_eop_bytes_b),
    .TX_VALID(tx_valid_b), .TX_READY(tx_ready),
    .HDR_CAPLEN(hdr_caplen_b), .HDR_LEN(hdr_len_b), .HDR_TS_SEC(hdr_sec_b), .HDR_TS_USEC(hdr_usec_b),
    .HDR_VALID(hdr_valid_b), .HDR_READY(hdr_ready), .ORPHAN_ERR(orphan_b));

  typedef struct packed {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [3:0]  eb;
  } tx_t;

  typedef struct packed {
    logic [31:0] caplen;
    logic [31:0] len;
    logic [31:0] sec;
    logic [31:0] usec;
  } hdr_t;

  tx_t  txq_a[$], txq_b[$];
  hdr_t hq_a[$],  hq_b[$];
  int   vectors = 0;
  int   errs = 0;
  int   orphan_cnt_a = 0;
  int   orphan_cnt_b = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    errs++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [63:0] mask(input logic [63:0] d, input logic [3:0] eb);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) if (b < int'(eb)) m[b*8 +: 8] = 8'hFF;
    return d & m;
  endfunction

  function automatic logic [63:0] mkword(input logic [7:0] base, input int w);
    logic [63:0] d;
    for (int b = 0; b < 8; b++) d[b*8 +: 8] = base + 8'(w*8 + b);
    return d;
  endfunction

  function automatic logic cur_rdy();
    return sel ? rx_ready_b : rx_ready_a;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic mon_tx(input bit which, input tx_t act);
    tx_t e;
    logic [3:0] n;
    if (which ? (txq_b.size() == 0) : (txq_a.size() == 0)) begin
      fail_now($sformatf("tx_%0d unexpected word: got %0h, expected none", which, act.d));
      return;
    end
    e = which ? txq_b.pop_front() : txq_a.pop_front();
    n = e.eop ? e.eb : 4'd8;
    chk($sformatf("tx_%0d sop", which), act.sop, e.sop);
    chk($sformatf("tx_%0d eop", which), act.eop, e.eop);
    if (e.eop) chk($sformatf("tx_%0d eop_bytes", which), act.eb, e.eb);
    chk($sformatf("tx_%0d data", which), mask(act.d, n), mask(e.d, n));
  endtask

  task automatic mon_hdr(input bit which, input hdr_t act);
    hdr_t e;
    if (which ? (hq_b.size() == 0) : (hq_a.size() == 0)) begin
      fail_now($sformatf("hdr_%0d unexpected header: got caplen %0d len %0d, expected none",
                         which, act.caplen, act.len));
      return;
    end
    e = which ? hq_b.pop_front() : hq_a.pop_front();
    chk($sformatf("hdr_%0d caplen", which), act.caplen, e.caplen);
    chk($sformatf("hdr_%0d len", which), act.len, e.len);
    chk($sformatf("hdr_%0d ts_sec", which), act.sec, e.sec);
    chk($sformatf("hdr_%0d ts_usec", which), act.usec, e.usec);
  endtask

  always @(negedge clk) begin
    if (orphan_a) orphan_cnt_a++;
    if (orphan_b) orphan_cnt_b++;
    if (tx_valid_a && tx_ready) mon_tx(1'b0, {tx_data_a, tx_sop_a, tx_eop_a, tx_eop_bytes_a});
    if (tx_valid_b && tx_ready) mon_tx(1'b1, {tx_data_b, tx_sop_b, tx_eop_b, tx_eop_bytes_b});
    if (hdr_valid_a && hdr_ready) mon_hdr(1'b0, {hdr_caplen_a, hdr_len_a, hdr_sec_a, hdr_usec_a});
    if (hdr_valid_b && hdr_ready) mon_hdr(1'b1, {hdr_caplen_b, hdr_len_b, hdr_sec_b, hdr_usec_b});
  end

  // ---------------- stimulus helpers ----------------
  task automatic exp_tx(input logic [63:0] d, input logic sop, input logic eop, input logic [3:0] eb);
    if (sel) txq_b.push_back({d, sop, eop, eb});
    else     txq_a.push_back({d, sop, eop, eb});
  endtask

  task automatic exp_hdr(input logic [31:0] caplen, input logic [31:0] len,
                         input logic [31:0] sec, input logic [31:0] usec);
    if (sel) hq_b.push_back({caplen, len, sec, usec});
    else     hq_a.push_back({caplen, len, sec, usec});
  endtask

  // Present one word and hold it until accepted; called at posedge+1
  task automatic send(input logic [63:0] d, input logic sop, input logic eop,
                      input logic [3:0] eb, output int waits);
    logic r;
    rx_data = d; rx_sop = sop; rx_eop = eop; rx_eop_bytes = eb; rx_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      r = cur_rdy();
      @(posedge clk);
      #1;
      if (r) break;
      waits++;
      if (waits > 500) begin
        fail_now("send timeout waiting for RX_READY");
        break;
      end
    end
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  // Whole packet of nbytes; pushes the pass-through TX words as expectations
  task automatic send_pkt(input int nbytes, input logic [7:0] base, input int stall);
    int n, w8;
    logic [3:0] eb;
    logic [63:0] d;
    logic last;
    n = (nbytes + 7) / 8;
    for (int w = 0; w < n; w++) begin
      d    = mkword(base, w);
      last = (w == n - 1);
      eb   = last ? 4'(nbytes - 8*(n-1)) : 4'd8;
      exp_tx(d, w == 0, last, last ? eb : 4'd0);
      if (w == 0 && stall > 0) begin
        tx_ready = 1'b0;
        rx_data = d; rx_sop = 1'b1; rx_eop = last; rx_eop_bytes = eb; rx_valid = 1'b1;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("rx_ready follows tx_ready=0", cur_rdy(), 1'b0);
          @(posedge clk);
          #1;
        end
        tx_ready = 1'b1;
      end
      send(d, w == 0, last, eb, w8);
      // Move the clock on after SOP so a late timestamp sample would be visible
      if (w == 0) begin ts_sec = ts_sec + 1; ts_usec = 32'd999; end
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (txq_a.size() + txq_b.size() + hq_a.size() + hq_b.size() != 0) begin
      @(negedge clk);
      c++;
      if (c > 300) begin
        fail_now("drain timeout: expected outputs never appeared");
        txq_a.delete(); txq_b.delete(); hq_a.delete(); hq_b.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    rst_n = 1'b0; sel = 1'b0; ts_sec = '0; ts_usec = '0;
    rx_data = 64'h1122_3344_5566_7788; rx_sop = 1'b1; rx_eop = 1'b0; rx_eop_bytes = 4'd0;
    rx_valid = 1'b1; tx_ready = 1'b1; hdr_ready = 1'b1;

    // Reset: a presented SOP word must not leak through
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rx_ready", rx_ready_a, 1'b0);
    chk("reset tx_valid", tx_valid_a, 1'b0);
    chk("reset tx_data", tx_data_a, 64'd0);
    chk("reset tx_sop", tx_sop_a, 1'b0);
    chk("reset hdr_valid", hdr_valid_a, 1'b0);
    chk("reset orphan", orphan_a, 1'b0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rx_sop = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 60-byte packet, full capture, SOP stalled two cycles by TX_READY
    ts_sec = 32'd5; ts_usec = 32'd100;
    exp_hdr(32'd60, 32'd60, 32'd5, 32'd100);
    send_pkt(60, 8'h00, 2);
    wait_drain();

    // SNAPLEN=20 instance: 3 words forwarded, rest dropped regardless of TX_READY
    sel = 1'b1;
    ts_sec = 32'd11; ts_usec = 32'd222;
    exp_hdr(32'd20, 32'd60, 32'd11, 32'd222);
    exp_tx(mkword(8'h40, 0), 1'b1, 1'b0, 4'd0);
    exp_tx(mkword(8'h40, 1), 1'b0, 1'b0, 4'd0);
    exp_tx(mkword(8'h40, 2), 1'b0, 1'b1, 4'd4);
    for (int i = 0; i < 3; i++) send(mkword(8'h40, i), i == 0, 1'b0, 4'd8, w);
    tx_ready = 1'b0;
    for (int i = 3; i < 8; i++) begin
      rx_data = mkword(8'h40, i); rx_sop = 1'b0; rx_eop = (i == 7);
      rx_eop_bytes = (i == 7) ? 4'd4 : 4'd8; rx_valid = 1'b1;
      @(negedge clk);
      chk("drop rx_ready", rx_ready_b, 1'b1);
      chk("drop tx_valid", tx_valid_b, 1'b0);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0; rx_eop = 1'b0;
    tx_ready = 1'b1;
    wait_drain();
    sel = 1'b0;

    // Single-word packet; header appears exactly one cycle after acceptance
    ts_sec = 32'd7; ts_usec = 32'd200;
    exp_tx(64'h0000_0000_0000_00A5, 1'b1, 1'b1, 4'd1);
    exp_hdr(32'd1, 32'd1, 32'd7, 32'd200);
    rx_data = 64'h0000_0000_0000_00A5; rx_sop = 1'b1; rx_eop = 1'b1; rx_eop_bytes = 4'd1;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("sop+eop rx_ready", rx_ready_a, 1'b1);
    chk("hdr not yet visible", hdr_valid_a, 1'b0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    @(negedge clk);
    chk("hdr visible next cycle", hdr_valid_a, 1'b1);
    @(posedge clk);
    #1;
    // FSM stayed in IDLE: the next SOP word is forwarded as SOP
    exp_hdr(32'd3, 32'd3, 32'd7, 32'd200);
    send_pkt(3, 8'h90, 0);
    wait_drain();

    // Header FIFO fill: eight stored, ninth EOP stalls until one pop
    hdr_ready = 1'b0;
    ts_sec = 32'd1; ts_usec = 32'd2;
    for (int i = 0; i < 8; i++) begin
      ts_sec = 32'd1; ts_usec = 32'd2;
      exp_hdr(32'd8, 32'd8, 32'd1, 32'd2);
      send_pkt(8, 8'(i * 16), 0);
    end
    ts_sec = 32'd3; ts_usec = 32'd4;
    exp_tx(mkword(8'hF0, 0), 1'b1, 1'b1, 4'd8);
    exp_hdr(32'd8, 32'd8, 32'd3, 32'd4);
    rx_data = mkword(8'hF0, 0); rx_sop = 1'b1; rx_eop = 1'b1; rx_eop_bytes = 4'd8;
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full fifo stalls rx_ready", rx_ready_a, 1'b0);
      chk("full fifo holds tx_valid", tx_valid_a, 1'b0);
      @(posedge clk);
      #1;
    end
    hdr_ready = 1'b1;
    @(negedge clk);
    chk("pop releases rx_ready", rx_ready_a, 1'b1);
    @(posedge clk);
    #1;
    hdr_ready = 1'b0; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    @(negedge clk);
    chk("fifo full again after swap", hdr_valid_a, 1'b1);
    @(posedge clk);
    #1;
    hdr_ready = 1'b1;
    wait_drain();

    // Orphan word in IDLE: consumed even with TX_READY low, no output, no header
    tx_ready = 1'b0;
    rx_data = 64'hDEAD_BEEF_0000_0001; rx_sop = 1'b0; rx_eop = 1'b0; rx_valid = 1'b1;
    @(negedge clk);
    chk("orphan rx_ready", rx_ready_a, 1'b1);
    chk("orphan tx_valid", tx_valid_a, 1'b0);
    chk("orphan pulse", orphan_a, 1'b1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    chk("orphan pulse ends", orphan_a, 1'b0);
    chk("orphan count", 64'(orphan_cnt_a), 64'd1);
    @(posedge clk);
    #1;
    ts_sec = 32'd8; ts_usec = 32'd300;
    exp_hdr(32'd12, 32'd12, 32'd8, 32'd300);
    send_pkt(12, 8'hC0, 0);
    wait_drain();

    // Reset mid-packet: a held header and the partial packet are both discarded
    hdr_ready = 1'b0;
    send_pkt(4, 8'hD0, 0);            // header intentionally left unexpected
    @(negedge clk);
    chk("held header present", hdr_valid_a, 1'b1);
    @(posedge clk);
    #1;
    ts_sec = 32'd9; ts_usec = 32'd400;
    exp_tx(mkword(8'h60, 0), 1'b1, 1'b0, 4'd0);
    exp_tx(mkword(8'h60, 1), 1'b0, 1'b0, 4'd0);
    send(mkword(8'h60, 0), 1'b1, 1'b0, 4'd8, w);
    send(mkword(8'h60, 1), 1'b0, 1'b0, 4'd8, w);
    rx_data = mkword(8'h60, 2); rx_valid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid reset rx_ready", rx_ready_a, 1'b0);
    chk("mid reset tx_valid", tx_valid_a, 1'b0);
    chk("mid reset tx_data", tx_data_a, 64'd0);
    chk("mid reset hdr_valid", hdr_valid_a, 1'b0);
    chk("mid reset hdr_caplen", hdr_caplen_a, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; rx_valid = 1'b0;
    hdr_ready = 1'b1;
    @(negedge clk);
    chk("no header after reset", hdr_valid_a, 1'b0);
    @(posedge clk);
    #1;
    ts_sec = 32'd10; ts_usec = 32'd500;
    exp_hdr(32'd10, 32'd10, 32'd10, 32'd500);
    send_pkt(10, 8'hE0, 0);
    wait_drain();

    repeat (4) @(posedge clk);
    chk("total orphan pulses a", 64'(orphan_cnt_a), 64'd1);
    chk("total orphan pulses b", 64'(orphan_cnt_b), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  // Absolute guard so the run always ends
  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs + 1);
    $finish;
  end

endmodule

// File: doc/pcap_record_framer.md
Name: pcap_record_framer

Overview:
- Capture-side stage feeding the PCAP dumper in verification environments and the on-chip capture path.
- Takes a byte-granular packet stream, timestamps each packet at SOP and truncates the data to SNAPLEN.
- Emits the truncated data stream plus one per-packet record header (caplen, len, ts_sec, ts_usec) on a separate buffered interface.
- The downstream writer pairs one header with one truncated packet to form the pcap record.

Parameters:
DATA_WIDTH, 64, data bus width in bits; multiple of 8; BYTES = DATA_WIDTH/8 (must be at least 2).
SNAPLEN, 65535, maximum captured bytes per packet; must be at least 1.
HDR_FIFO_DEPTH, 8, header FIFO entries; power of two, at least 2.

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
TS_SEC  in  32  free-running timestamp seconds
TS_USEC  in  32  free-running timestamp microseconds
RX_DATA  in  DATA_WIDTH  packet bytes; byte 0 in bits [7:0]
RX_SOP  in  1  first word of packet
RX_EOP  in  1  last word of packet
RX_EOP_BYTES  in  $clog2(BYTES)+1  valid bytes in EOP word (1..BYTES); ignored when RX_EOP=0
RX_VALID  in  1  input word valid
RX_READY  out  1  input word accepted when RX_VALID and RX_READY
TX_DATA  out  DATA_WIDTH  truncated packet bytes
TX_SOP  out  1  first output word
TX_EOP  out  1  last output word
TX_EOP_BYTES  out  $clog2(BYTES)+1  valid bytes in TX EOP word
TX_VALID  out  1  output word valid
TX_READY  in  1  downstream accepts output word
HDR_CAPLEN  out  32  min(len, SNAPLEN)
HDR_LEN  out  32  original packet length in bytes (saturating)
HDR_TS_SEC  out  32  TS_SEC sampled at accepted SOP
HDR_TS_USEC  out  32  TS_USEC sampled at accepted SOP
HDR_VALID  out  1  header FIFO not empty
HDR_READY  in  1  pops header
ORPHAN_ERR  out  1  one-cycle pulse: non-SOP word accepted in IDLE

Behaviour:
- Reset (RESET_N=0, async assert, sync deassert): FSM=IDLE; counters, TS registers and FIFO pointers cleared. All outputs 0 except RX_READY, which is also 0 while in reset. Reset mid-packet discards the partial packet and its header.
- FSM IDLE:
  - Accepted word with RX_SOP=1: capture TS, set len to its byte count, forward it with TX_SOP=1, go to PASS.
  - If the SOP word also has RX_EOP=1, the packet completes in the same cycle and the FSM stays in IDLE.
  - Accepted word with RX_SOP=0: consumed, not forwarded, ORPHAN_ERR=1 for that cycle, FSM stays in IDLE.
- FSM PASS: each accepted word adds its bytes to len. A word whose cumulative byte count reaches or exceeds SNAPLEN is forwarded with TX_EOP=1 and TX_EOP_BYTES = SNAPLEN - bytes_before. If that word lacks RX_EOP, go to DROP; otherwise go to IDLE.
- FSM DROP: words are consumed and not forwarded; len keeps counting. RX_EOP goes to IDLE.
- RX_SOP seen in PASS or DROP is ignored and the word is treated as a continuation.
- Packet completion (accepted RX_EOP word): push {caplen, len, ts_sec, ts_usec} to the header FIFO in that cycle. HDR_* becomes visible the next cycle (1-cycle latency).
- len is 32-bit and saturates at 0xFFFFFFFF.
- Bytes beyond RX_EOP_BYTES in TX_DATA are don't-care.
- Data path: combinational pass-through; TX_VALID = RX_VALID while forwarding.
- RX_READY:
  - Forwarded word: RX_READY = TX_READY.
  - Dropped word (DROP or orphan): RX_READY = 1.
  - Any word carrying RX_EOP (SOP+EOP included): additionally requires the header FIFO not full, counting a same-cycle pop as freeing a slot.
  - Consequence: RX_READY never depends on RX_VALID in a way that creates a loop through TX_READY->TX_VALID.
- Header FIFO: simultaneous push and pop when full is allowed; push and pop when empty makes the entry visible next cycle. HDR_* outputs are stable while HDR_VALID=1 and HDR_READY=0.
- Stable-data rule: the TX_* outputs hold while TX_VALID=1 and TX_READY=0, which follows from upstream holding RX_*.

Test Plan:
- DATA_WIDTH=64, SNAPLEN=65535; 60-byte packet (8 words, EOP_BYTES=4), TS_SEC=5, TS_USEC=100 at SOP -> 8 TX words identical to input; header caplen=60, len=60, ts_sec=5, ts_usec=100.
- SNAPLEN=20; 60-byte packet -> 3 TX words, TX_EOP on word 3 with TX_EOP_BYTES=4; words 4-8 dropped with RX_READY=1 regardless of TX_READY; header caplen=20, len=60.
- Single-word packet (SOP+EOP, EOP_BYTES=1) -> one TX word with SOP=EOP=1; header caplen=1, len=1; FSM stays in IDLE.
- HDR_READY=0, HDR_FIFO_DEPTH=8, nine 8-byte packets -> eight headers stored; the ninth packet's EOP word is stalled (RX_READY=0). One HDR pop releases it, and its header appears one cycle after acceptance.
- Word with RX_SOP=0 in IDLE -> ORPHAN_ERR pulses once, no TX_VALID, no header; the following SOP packet passes normally.
- Assert RESET_N=0 mid-packet (after 2 of 8 words) -> all outputs 0, FIFO empty. After release, the next SOP packet yields a correct header and the partial packet produces no header.
